serial_load_ctrl: RTL and testbench

//   Upstream feeder for the N-bit enable-gated register stage.

---
 rtl/serial_load_ctrl_pkg.sv | 19 +
 rtl/serial_load_ctrl_bit_counter.sv | 18 +
 rtl/serial_load_ctrl.sv | 89 ++++++++
 tb/tb_serial_load_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_load_ctrl_pkg.sv
// Shared definitions for the serial word loader: FSM state encoding and the
// constant clog2 used to size the bit counter.
package serial_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Elaboration-time ceiling log2; callers guarantee v >= 2, so the result is >= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_load_ctrl_bit_counter.sv
// Counts accepted serial bits within a frame. Synchronous clear wins over increment.
module bit_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (inc)     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/serial_load_ctrl.sv
// Assembles an N-bit word from a gated serial stream and issues one registered
// en strobe per completed word, with d presented alongside it.
module serial_load_ctrl
  import serial_load_ctrl_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sin,
  input  logic         sin_valid,
  output logic         busy,
  output logic         en,
  output logic [N-1:0] d
);

  localparam int CW = clog2(N);

  state_e         state;
  logic [N-1:0]   sh;
  logic [N-1:0]   sh_next;
  logic [CW-1:0]  cnt;
  logic           last_bit;
  logic           cnt_clr;
  logic           cnt_inc;

  assign last_bit = (cnt == CW'(N - 1));
  assign cnt_clr  = (state == ST_IDLE) && start;
  // The Nth bit leaves SHIFT instead of counting, so the counter never wraps.
  assign cnt_inc  = (state == ST_SHIFT) && sin_valid && !last_bit;

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    sh_next = sh;
    if (MSB_FIRST) sh_next = {sh[N-2:0], sin};
    else           sh_next = {sin, sh[N-1:1]};
  end

  bit_counter #(.W(CW)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sh    <= '0;
      d     <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            sh    <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sin_valid) begin
            sh <= sh_next;
            if (last_bit) begin
              // Capture sh_next, not sh, so the word includes the bit accepted this edge.
              d     <= sh_next;
              en    <= 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Self-checking bench: cycle table, corner-case sequences, and a randomized run
// against a frame-level reference model, across three parameterisations.
module tb_serial_load_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 0, sin_a = 0, valid_a = 0, busy_a, en_a;
  logic start_b = 0, sin_b = 0, valid_b = 0, busy_b, en_b;
  logic start_c = 0, sin_c = 0, valid_c = 0, busy_c, en_c;
  logic [3:0] d_a, d_b, q_a;
  logic [7:0] d_c;

  serial_load_ctrl #(.N(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .sin(sin_a), .sin_valid(valid_a),
    .busy(busy_a), .en(en_a), .d(d_a));
  serial_load_ctrl #(.N(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .sin(sin_b), .sin_valid(valid_b),
    .busy(busy_b), .en(en_b), .d(d_b));
  serial_load_ctrl #(.N(8), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(rst), .start(start_c), .sin(sin_c), .sin_valid(valid_c),
    .busy(busy_c), .en(en_c), .d(d_c));

  // Downstream enable-gated register fed by instance A.
  always @(posedge clk) begin
    if (rst)       q_a <= '0;
    else if (en_a) q_a <= d_a;
  end

  int en_pulses_a = 0;
  always @(negedge clk) if (en_a) en_pulses_a++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: a frame collects N accepted bits into an integer.
  typedef struct {
    int phase;   // 0 idle, 1 collecting, 2 word delivered this cycle
    int nbits;
    int acc;
    int d;
  } mdl_t;

  task automatic model_step(input int n, input bit msb, input mdl_t mi,
                            input bit rs, input bit st, input bit s, input bit v,
                            output mdl_t mo);
    mo = mi;
    if (rs) begin
      mo.phase = 0; mo.nbits = 0; mo.acc = 0; mo.d = 0;
    end else if (mi.phase == 0) begin
      if (st) begin mo.phase = 1; mo.nbits = 0; mo.acc = 0; end
    end else if (mi.phase == 1) begin
      if (v) begin
        if (msb) mo.acc = mi.acc * 2 + int'(s);
        else     mo.acc = mi.acc + (int'(s) << mi.nbits);
        mo.nbits = mi.nbits + 1;
        if (mo.nbits == n) begin mo.d = mo.acc; mo.phase = 2; end
      end
    end else begin
      mo.phase = 0;
    end
  endtask

  typedef struct {
    logic rs, st, s, v;
    logic en, busy;
    logic [3:0] d, q;
  } vec_t;

  vec_t tbl[15];

  initial begin
    mdl_t ma, mb, na, nb;
    int stalls;
    logic [3:0] bits3, bits5, bits6;
    logic [7:0] bits_c;

    // reset, frame 1011, restart-ignored frame 1101, start in LOAD ignored
    tbl[0]  = '{1,1,1,1, 0,0, 4'h0, 4'h0};
    tbl[1]  = '{1,0,0,1, 0,0, 4'h0, 4'h0};
    tbl[2]  = '{0,1,0,1, 0,1, 4'h0, 4'h0};
    tbl[3]  = '{0,0,1,1, 0,1, 4'h0, 4'h0};
    tbl[4]  = '{0,0,0,1, 0,1, 4'h0, 4'h0};
    tbl[5]  = '{0,0,1,1, 0,1, 4'h0, 4'h0};
    tbl[6]  = '{0,0,1,1, 1,1, 4'hB, 4'h0};
    tbl[7]  = '{0,0,0,0, 0,0, 4'hB, 4'hB};
    tbl[8]  = '{0,1,0,0, 0,1, 4'hB, 4'hB};
    tbl[9]  = '{0,0,1,1, 0,1, 4'hB, 4'hB};
    tbl[10] = '{0,0,1,1, 0,1, 4'hB, 4'hB};
    tbl[11] = '{0,1,0,1, 0,1, 4'hB, 4'hB};
    tbl[12] = '{0,0,1,1, 1,1, 4'hD, 4'hB};
    tbl[13] = '{0,1,0,0, 0,0, 4'hD, 4'hD};
    tbl[14] = '{0,0,0,0, 0,0, 4'hD, 4'hD};

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rs; start_a = tbl[i].st; sin_a = tbl[i].s; valid_a = tbl[i].v;
      tick();
      check($sformatf("tbl%0d_en", i),   32'(en_a),   32'(tbl[i].en));
      check($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_d", i),    32'(d_a),    32'(tbl[i].d));
      check($sformatf("tbl%0d_q", i),    32'(q_a),    32'(tbl[i].q));
    end
    start_a = 0; valid_a = 0;

    // Stalled frame 0,1,1,0: one pulse, only after the last bit.
    bits3 = 4'b0110;
    en_pulses_a = 0;
    start_a = 1; tick(); start_a = 0;
    for (int i = 3; i >= 0; i--) begin
      sin_a = bits3[i]; valid_a = 1; tick(); valid_a = 0;
      if (i > 0) begin
        stalls = $urandom_range(1, 3);
        for (int k = 0; k < stalls; k++) begin sin_a = 1'($urandom); tick(); end
        check("stall_no_early_en", 32'(en_pulses_a), 32'd0);
        check("stall_busy", 32'(busy_a), 32'd1);
      end
    end
    repeat (3) tick();
    check("stall_en_pulses", 32'(en_pulses_a), 32'd1);
    check("stall_d", 32'(d_a), 32'h6);
    check("stall_q", 32'(q_a), 32'h6);

    // Reset after two bits aborts the frame, then a clean 1111 frame.
    en_pulses_a = 0;
    start_a = 1; tick(); start_a = 0;
    sin_a = 1; valid_a = 1; tick(); tick(); valid_a = 0;
    rst = 1; tick(); rst = 0;
    tick();
    check("abort_en_pulses", 32'(en_pulses_a), 32'd0);
    check("abort_d", 32'(d_a), 32'h0);
    check("abort_busy", 32'(busy_a), 32'd0);
    bits5 = 4'b1111;
    start_a = 1; tick(); start_a = 0;
    for (int i = 3; i >= 0; i--) begin sin_a = bits5[i]; valid_a = 1; tick(); end
    valid_a = 0;
    check("after_abort_en", 32'(en_a), 32'd1);
    check("after_abort_d", 32'(d_a), 32'hF);
    tick();
    check("after_abort_q", 32'(q_a), 32'hF);
    check("after_abort_idle", 32'(busy_a), 32'd0);

    // LSB-first: first bit lands in d[0].
    bits6 = 4'b1000;
    start_b = 1; tick(); start_b = 0;
    for (int i = 3; i >= 0; i--) begin sin_b = bits6[i]; valid_b = 1; tick(); end
    valid_b = 0;
    check("lsb_en", 32'(en_b), 32'd1);
    check("lsb_d", 32'(d_b), 32'h1);

    // N=8 MSB-first.
    bits_c = 8'b1010_0101;
    start_c = 1; tick(); start_c = 0;
    for (int i = 7; i >= 0; i--) begin
      sin_c = bits_c[i]; valid_c = 1; tick();
      if (i > 0) check("n8_no_early_en", 32'(en_c), 32'd0);
    end
    valid_c = 0;
    check("n8_en", 32'(en_c), 32'd1);
    check("n8_d", 32'(d_c), 32'hA5);
    tick();
    check("n8_en_drop", 32'(en_c), 32'd0);
    check("n8_idle", 32'(busy_c), 32'd0);
    check("n8_d_hold", 32'(d_c), 32'hA5);

    // Randomized run on A and B against the reference model.
    ma = '{0, 0, 0, 0}; mb = '{0, 0, 0, 0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst     = (cyc == 0) || ($urandom_range(0, 39) == 0);
      start_a = ($urandom_range(0, 5) == 0);
      sin_a   = 1'($urandom);
      valid_a = 1'($urandom);
      start_b = ($urandom_range(0, 5) == 0);
      sin_b   = 1'($urandom);
      valid_b = 1'($urandom);
      model_step(4, 1'b1, ma, rst, start_a, sin_a, valid_a, na);
      model_step(4, 1'b0, mb, rst, start_b, sin_b, valid_b, nb);
      ma = na; mb = nb;
      tick();
      check("rnd_a_en",   32'(en_a),   32'(ma.phase == 2));
      check("rnd_a_busy", 32'(busy_a), 32'(ma.phase != 0));
      check("rnd_a_d",    32'(d_a),    32'(ma.d));
      check("rnd_b_en",   32'(en_b),   32'(mb.phase == 2));
      check("rnd_b_busy", 32'(busy_b), 32'(mb.phase != 0));
      check("rnd_b_d",    32'(d_b),    32'(mb.d));
    end
    rst = 0; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
